instruction_fetch: RTL and testbench

INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

---
 rtl/instruction_fetch.sv | 152 +++++++++++++++
 tb/tb_instruction_fetch.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch.sv
// Instruction fetch unit: requests one instruction word per PC, holds it for
// the datapath until exec_done, then advances the PC (plus1, relative
// branch, or absolute jump). A memory that never acknowledges sends the
// unit into a terminal HALT state with a sticky fetch_err flag.
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   imem_req/addr       read request and address (address = pc)
//   imem_ack/rdata      read data valid strobe and data
//   instr/instr_valid   registered instruction and its valid flag
//   pc                  address of instr
//   exec_done           datapath finished instr; PC selects sampled now
//   sel_PCSrc_*         PC-source selects (const > offset > plus1)
//   branch_cond         condition for the relative branch
//   jump_offset         signed 8-bit branch offset
//   jump_target         absolute jump target
//   fetch_err           sticky memory-timeout flag
module instruction_fetch #(
  parameter int unsigned PC_W    = 12,
  parameter int unsigned INSTR_W = 19,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic               clk,
  input  logic               rst,
  output logic               imem_req,
  output logic [PC_W-1:0]    imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic [INSTR_W-1:0] instr,
  output logic               instr_valid,
  output logic [PC_W-1:0]    pc,
  input  logic               exec_done,
  input  logic               sel_PCSrc_plus1,
  input  logic               sel_PCSrc_offset,
  input  logic               sel_PCSrc_const,
  input  logic               branch_cond,
  input  logic [7:0]         jump_offset,
  input  logic [PC_W-1:0]    jump_target,
  output logic               fetch_err
);

  localparam int unsigned CntW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {StFetch, StWait, StIssue, StHalt} state_e;

  state_e             state_q, state_d;
  logic [PC_W-1:0]    pc_q, pc_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic               err_q, err_d;

  logic signed [7:0]  offset_s;
  logic [PC_W-1:0]    offset_ext;
  logic [PC_W-1:0]    pc_plus1;
  logic [PC_W-1:0]    pc_branch;
  logic [PC_W-1:0]    pc_next;
  logic [CntW-1:0]    cnt_inc;

  // PC arithmetic wraps naturally at PC_W bits.
  assign offset_s   = jump_offset;
  assign offset_ext = PC_W'(offset_s);
  assign pc_plus1   = pc_q + PC_W'(1);
  assign pc_branch  = pc_plus1 + offset_ext;
  assign cnt_inc    = cnt_q + CntW'(1);

  always_comb begin
    pc_next = pc_plus1;
    if (sel_PCSrc_const) begin
      pc_next = jump_target;
    end else if (sel_PCSrc_offset && branch_cond) begin
      pc_next = pc_branch;
    end else if (sel_PCSrc_plus1) begin
      // Explicit plus1 and "no select" both fall through to pc+1.
      pc_next = pc_plus1;
    end
  end

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    instr_d     = instr_q;
    cnt_d       = cnt_q;
    err_d       = err_q;
    imem_req    = 1'b0;
    instr_valid = 1'b0;

    unique case (state_q)
      StFetch: begin
        imem_req = 1'b1;
        cnt_d    = '0;
        if (imem_ack) begin
          instr_d = imem_rdata;
          state_d = StIssue;
        end else begin
          state_d = StWait;
        end
      end
      StWait: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          instr_d = imem_rdata;
          state_d = StIssue;
        end else begin
          cnt_d = cnt_inc;
          if (cnt_inc == CntW'(TIMEOUT)) begin
            err_d   = 1'b1;
            state_d = StHalt;
          end
        end
      end
      StIssue: begin
        instr_valid = 1'b1;
        if (exec_done) begin
          pc_d    = pc_next;
          state_d = StFetch;
        end
      end
      StHalt: begin
        // Terminal until reset.
      end
      default: state_d = StFetch;
    endcase

    // Outputs stay quiet while reset is held.
    if (rst) begin
      imem_req    = 1'b0;
      instr_valid = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StFetch;
      pc_q    <= '0;
      instr_q <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  assign imem_addr = pc_q;
  assign pc        = pc_q;
  assign instr     = instr_q;
  assign fetch_err = err_q;

endmodule

// File: tb/tb_instruction_fetch.sv
module tb_instruction_fetch;

  logic        clk;
  logic        rst;
  logic        imem_req;
  logic [11:0] imem_addr;
  logic        imem_ack;
  logic [18:0] imem_rdata;
  logic [18:0] instr;
  logic        instr_valid;
  logic [11:0] pc;
  logic        exec_done;
  logic        sel_plus1, sel_offset, sel_const;
  logic        branch_cond;
  logic [7:0]  jump_offset;
  logic [11:0] jump_target;
  logic        fetch_err;

  int n_checks = 0;
  int n_fail   = 0;

  instruction_fetch #(
    .PC_W   (12),
    .INSTR_W(19),
    .TIMEOUT(15)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .imem_req        (imem_req),
    .imem_addr       (imem_addr),
    .imem_ack        (imem_ack),
    .imem_rdata      (imem_rdata),
    .instr           (instr),
    .instr_valid     (instr_valid),
    .pc              (pc),
    .exec_done       (exec_done),
    .sel_PCSrc_plus1 (sel_plus1),
    .sel_PCSrc_offset(sel_offset),
    .sel_PCSrc_const (sel_const),
    .branch_cond     (branch_cond),
    .jump_offset     (jump_offset),
    .jump_target     (jump_target),
    .fetch_err       (fetch_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        p1;
    logic        of;
    logic        bc;
    logic        cs;
    logic [7:0]  off;
    logic [11:0] tgt;
    logic [18:0] data;
    int          waits;
    int          hold;
    logic [11:0] next;
  } vec_t;

  vec_t vecs [0:10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Entered at a negedge with the DUT in FETCH; leaves it in ISSUE.
  task automatic serve(input int waits, input logic [18:0] data, input logic [11:0] addr);
    #1;
    check("fetch_req", 32'(imem_req), 32'd1);
    check("fetch_addr", 32'(imem_addr), 32'(addr));
    imem_ack = 1'b0;
    for (int i = 0; i < waits; i++) tick();
    if (waits > 0) begin
      check("wait_req", 32'(imem_req), 32'd1);
      check("wait_addr", 32'(imem_addr), 32'(addr));
      check("wait_valid", 32'(instr_valid), 32'd0);
    end
    imem_ack   = 1'b1;
    imem_rdata = data;
    tick();
    imem_ack   = 1'b0;
    imem_rdata = '0;
    check("issue_valid", 32'(instr_valid), 32'd1);
    check("issue_instr", 32'(instr), 32'(data));
    check("issue_pc", 32'(pc), 32'(addr));
    check("issue_err", 32'(fetch_err), 32'd0);
  endtask

  // Entered in the first ISSUE cycle; leaves the DUT in FETCH.
  task automatic issue(input int hold, input logic p1, input logic of, input logic bc,
                       input logic cs, input logic [7:0] off, input logic [11:0] tgt,
                       input logic [18:0] exp_instr, input logic [11:0] exp_next);
    sel_plus1   = p1;
    sel_offset  = of;
    branch_cond = bc;
    sel_const   = cs;
    jump_offset = off;
    jump_target = tgt;
    exec_done   = 1'b0;
    for (int i = 1; i < hold; i++) begin
      tick();
      check("hold_valid", 32'(instr_valid), 32'd1);
      check("hold_instr", 32'(instr), 32'(exp_instr));
    end
    exec_done = 1'b1;
    tick();
    exec_done   = 1'b0;
    sel_plus1   = 1'b0;
    sel_offset  = 1'b0;
    branch_cond = 1'b0;
    sel_const   = 1'b0;
    check("drop_valid", 32'(instr_valid), 32'd0);
    check("next_addr", 32'(imem_addr), 32'(exp_next));
  endtask

  initial begin
    vecs[0]  = '{1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 12'h005, 19'h00A01, 0,  1, 12'h005};
    vecs[1]  = '{1'b0, 1'b1, 1'b1, 1'b0, 8'hFD, 12'h000, 19'h7FFFF, 1,  2, 12'h003};
    vecs[2]  = '{1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 12'h005, 19'h2AAAA, 2,  1, 12'h005};
    vecs[3]  = '{1'b0, 1'b1, 1'b0, 1'b0, 8'hFD, 12'h000, 19'h55555, 0,  3, 12'h006};
    vecs[4]  = '{1'b1, 1'b1, 1'b1, 1'b1, 8'h01, 12'h800, 19'h1E0F0, 3,  1, 12'h800};
    vecs[5]  = '{1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 12'hFFF, 19'h00F0F, 0,  1, 12'hFFF};
    vecs[6]  = '{1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 12'h000, 19'h3C3C3, 0,  2, 12'h000};
    vecs[7]  = '{1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 12'h002, 19'h12121, 1,  1, 12'h002};
    vecs[8]  = '{1'b0, 1'b1, 1'b1, 1'b0, 8'hF8, 12'h000, 19'h6B6B6, 0,  1, 12'hFFB};
    vecs[9]  = '{1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 12'h000, 19'h0BEEF, 15, 1, 12'hFFC};
    vecs[10] = '{1'b0, 1'b1, 1'b1, 1'b0, 8'h7F, 12'h000, 19'h4D4D4, 2,  1, 12'h07C};

    rst         = 1'b1;
    imem_ack    = 1'b0;
    imem_rdata  = '0;
    exec_done   = 1'b0;
    sel_plus1   = 1'b0;
    sel_offset  = 1'b0;
    sel_const   = 1'b0;
    branch_cond = 1'b0;
    jump_offset = '0;
    jump_target = '0;

    // Reset state.
    tick(); tick(); tick();
    check("rst_req", 32'(imem_req), 32'd0);
    check("rst_pc", 32'(pc), 32'd0);
    check("rst_instr", 32'(instr), 32'd0);
    check("rst_valid", 32'(instr_valid), 32'd0);
    check("rst_err", 32'(fetch_err), 32'd0);
    rst = 1'b0;

    // One-cycle memory, instr valid exactly two cycles, then address 1.
    serve(0, 19'h12345, 12'h000);
    issue(2, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 12'h000, 19'h12345, 12'h001);

    // Table of PC-source cases, chained from address 1.
    begin
      logic [11:0] cur;
      cur = 12'h001;
      for (int i = 0; i < 11; i++) begin
        serve(vecs[i].waits, vecs[i].data, cur);
        issue(vecs[i].hold, vecs[i].p1, vecs[i].of, vecs[i].bc, vecs[i].cs, vecs[i].off,
              vecs[i].tgt, vecs[i].data, vecs[i].next);
        cur = vecs[i].next;
      end
    end

    // exec_done outside ISSUE and ack outside FETCH/WAIT are ignored.
    imem_ack    = 1'b0;
    exec_done   = 1'b1;
    sel_const   = 1'b1;
    jump_target = 12'h123;
    tick(); tick();
    check("ign_done_addr", 32'(imem_addr), 32'h07C);
    check("ign_done_valid", 32'(instr_valid), 32'd0);
    exec_done  = 1'b0;
    sel_const  = 1'b0;
    imem_ack   = 1'b1;
    imem_rdata = 19'h11111;
    tick();
    imem_rdata = 19'h22222;
    tick();
    imem_ack = 1'b0;
    check("ign_ack_instr", 32'(instr), 32'h11111);
    check("ign_ack_valid", 32'(instr_valid), 32'd1);
    issue(1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 12'h000, 19'h11111, 12'h07D);

    // Reset during WAIT with a coincident ack discards the data.
    imem_ack = 1'b0;
    tick();
    rst        = 1'b1;
    imem_ack   = 1'b1;
    imem_rdata = 19'h33333;
    tick();
    check("wrst_req", 32'(imem_req), 32'd0);
    check("wrst_pc", 32'(pc), 32'd0);
    check("wrst_instr", 32'(instr), 32'd0);
    check("wrst_valid", 32'(instr_valid), 32'd0);
    rst        = 1'b0;
    imem_ack   = 1'b0;
    imem_rdata = '0;
    serve(0, 19'h0ABCD, 12'h000);
    issue(1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 12'h000, 19'h0ABCD, 12'h001);

    // Timeout: 14 unacked WAIT cycles still requesting, the 15th halts.
    imem_ack = 1'b0;
    for (int i = 0; i < 15; i++) tick();
    check("to_edge_req", 32'(imem_req), 32'd1);
    check("to_edge_err", 32'(fetch_err), 32'd0);
    tick();
    check("halt_req", 32'(imem_req), 32'd0);
    check("halt_err", 32'(fetch_err), 32'd1);
    check("halt_valid", 32'(instr_valid), 32'd0);
    imem_ack   = 1'b1;
    imem_rdata = 19'h44444;
    exec_done  = 1'b1;
    tick(); tick(); tick();
    check("halt_sticky_err", 32'(fetch_err), 32'd1);
    check("halt_sticky_req", 32'(imem_req), 32'd0);
    check("halt_sticky_valid", 32'(instr_valid), 32'd0);
    check("halt_instr", 32'(instr), 32'h0ABCD);
    imem_ack   = 1'b0;
    imem_rdata = '0;
    exec_done  = 1'b0;

    // Reset recovers from HALT and fetches from address 0.
    rst = 1'b1;
    tick(); tick();
    check("hrst_err", 32'(fetch_err), 32'd0);
    check("hrst_pc", 32'(pc), 32'd0);
    rst = 1'b0;
    serve(0, 19'h1F00F, 12'h000);
    issue(1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 12'h000, 19'h1F00F, 12'h001);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
